// File: rtl/vga_pkg.sv
// Shared constants, scroll state type and offset stepping helper for the
// VGA frame-buffer address path.
package vga_pkg;

    localparam int IMG_W    = 320;
    localparam int IMG_H    = 240;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int OFS_W    = 8;
    localparam int ADDR_W   = 17;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } scroll_state_e;

    // One scroll step with wrap-around inside 0..last.
    function automatic logic [OFS_W-1:0] next_offset(
        input logic [OFS_W-1:0] ofs,
        input logic             down,
        input logic [OFS_W-1:0] last
    );
        logic [OFS_W-1:0] res;
        if (down) begin
            res = (ofs == '0) ? last : ofs - OFS_W'(1);
        end else begin
            res = (ofs == last) ? '0 : ofs + OFS_W'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/scroll_addr_pipe_if.sv
// Bus between the VGA timing/scroll control side and the frame-buffer
// address stage; state is carried along for observability.
interface scroll_addr_pipe_if #(
    parameter int ADDR_W = 17
);

    logic                        tick;
    logic                        en;
    logic                        dir;
    logic [9:0]                  h_cnt;
    logic [9:0]                  v_cnt;
    logic                        valid_in;
    logic                        hsync_in;
    logic                        vsync_in;
    logic [ADDR_W-1:0]           pixel_addr;
    logic [vga_pkg::OFS_W-1:0]   offset;
    logic                        valid_out;
    logic                        hsync_out;
    logic                        vsync_out;
    vga_pkg::scroll_state_e      state;

    modport master (
        output tick, en, dir, h_cnt, v_cnt, valid_in, hsync_in, vsync_in,
        input  pixel_addr, offset, valid_out, hsync_out, vsync_out, state
    );

    modport slave (
        input  tick, en, dir, h_cnt, v_cnt, valid_in, hsync_in, vsync_in,
        output pixel_addr, offset, valid_out, hsync_out, vsync_out, state
    );

endinterface

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register with synchronous reset to a per-bit value.
module sync_delay_line #(
    parameter int               WIDTH   = 3,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/scroll_addr_pipe.sv
// Frame-buffer read address for a 2x-upscaled, vertically scrolling image;
// scroll steps are deferred to vertical blanking to avoid tearing.
module scroll_addr_pipe #(
    parameter int IMG_W    = 320,
    parameter int IMG_H    = 240,
    parameter int ADDR_W   = 17,
    parameter int BRAM_LAT = 1
) (
    input logic               clk,
    input logic               rst,
    scroll_addr_pipe_if.slave bus
);

    import vga_pkg::*;

    localparam logic [OFS_W-1:0] OFS_LAST = OFS_W'(IMG_H - 1);

    scroll_state_e    state_q, state_d;
    logic             pend_dir_q, pend_dir_d;
    logic [OFS_W-1:0] offset_q, offset_d;
    logic             blank;

    assign blank = (bus.v_cnt >= 10'(V_ACTIVE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            pend_dir_q <= 1'b0;
            offset_q   <= '0;
        end else begin
            state_q    <= state_d;
            pend_dir_q <= pend_dir_d;
            offset_q   <= offset_d;
        end
    end

    // A pending step is cancelled by en=0 before blanking is even considered.
    always_comb begin
        state_d    = state_q;
        pend_dir_d = pend_dir_q;
        offset_d   = offset_q;
        unique case (state_q)
            RUN: begin
                if (bus.tick && bus.en) begin
                    pend_dir_d = bus.dir;
                    state_d    = PEND;
                end
            end
            PEND: begin
                if (!bus.en) begin
                    state_d = RUN;
                end else if (blank) begin
                    offset_d = next_offset(offset_q, pend_dir_q, OFS_LAST);
                    state_d  = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    logic [8:0]        row_sum, row_wrap;
    logic              in_active;
    logic [ADDR_W-1:0] addr_d, addr_q;

    // Line pair index plus offset never exceeds 478, so one subtract wraps it.
    always_comb begin
        row_sum   = {1'b0, bus.v_cnt[9:1]} + {1'b0, offset_q};
        row_wrap  = (row_sum >= 9'(IMG_H)) ? row_sum - 9'(IMG_H) : row_sum;
        in_active = (bus.h_cnt < 10'(H_ACTIVE)) && !blank;
        addr_d    = '0;
        if (in_active) begin
            addr_d = ADDR_W'(row_wrap) * ADDR_W'(IMG_W) + ADDR_W'(bus.h_cnt[9:1]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    logic [2:0] sync_q;

    sync_delay_line #(
        .WIDTH   (3),
        .DEPTH   (1 + BRAM_LAT),
        .RST_VAL (3'b011)
    ) u_sync_delay (
        .clk (clk),
        .rst (rst),
        .d   ({bus.valid_in, bus.hsync_in, bus.vsync_in}),
        .q   (sync_q)
    );

    assign bus.pixel_addr = addr_q;
    assign bus.offset     = offset_q;
    assign bus.state      = state_q;
    assign bus.valid_out  = sync_q[2];
    assign bus.hsync_out  = sync_q[1];
    assign bus.vsync_out  = sync_q[0];

endmodule

// File: tb/tb_scroll_addr_pipe.sv
// Directed bench for scroll_addr_pipe: mapping, deferred/wrapping steps,
// cancel/drop, mid-frame reset and sync alignment at BRAM_LAT 1 and 2.
module tb_scroll_addr_pipe;

    import vga_pkg::*;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    scroll_addr_pipe_if #(.ADDR_W(17)) bus  ();
    scroll_addr_pipe_if #(.ADDR_W(17)) bus2 ();

    assign bus2.tick     = bus.tick;
    assign bus2.en       = bus.en;
    assign bus2.dir      = bus.dir;
    assign bus2.h_cnt    = bus.h_cnt;
    assign bus2.v_cnt    = bus.v_cnt;
    assign bus2.valid_in = bus.valid_in;
    assign bus2.hsync_in = bus.hsync_in;
    assign bus2.vsync_in = bus.vsync_in;

    scroll_addr_pipe #(.IMG_W(320), .IMG_H(240), .ADDR_W(17), .BRAM_LAT(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    scroll_addr_pipe #(.IMG_W(320), .IMG_H(240), .ADDR_W(17), .BRAM_LAT(2)) dut_lat2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pos(input int h, input int v);
        bus.h_cnt = 10'(h);
        bus.v_cnt = 10'(v);
    endtask

    task automatic do_step(input logic d);
        set_pos(0, 100);
        bus.dir  = d;
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        set_pos(0, 480);
        cyc();
    endtask

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // scoreboard for sync alignment
    logic [2:0]  exp_q1[$];
    logic [2:0]  exp_q2[$];
    logic [15:0] pat_valid;
    logic [15:0] pat_hsync;
    logic [15:0] pat_vsync;

    initial begin
        n_vec = 0;
        n_err = 0;
        bus.tick = 1'b0;
        bus.en = 1'b1;
        bus.dir = 1'b0;
        bus.valid_in = 1'b0;
        bus.hsync_in = 1'b1;
        bus.vsync_in = 1'b1;
        set_pos(0, 0);

        rst = 1'b1;
        repeat (3) cyc();
        check_vec("rst_offset", 32'(bus.offset), 0);
        check_vec("rst_addr", 32'(bus.pixel_addr), 0);
        check_vec("rst_state", 32'(bus.state), 32'(RUN));
        check_vec("rst_valid", 32'(bus.valid_out), 0);
        check_vec("rst_hsync", 32'(bus.hsync_out), 1);
        check_vec("rst_vsync", 32'(bus.vsync_out), 1);
        rst = 1'b0;

        // mapping
        set_pos(0, 0);     cyc(); check_vec("map_0_0", 32'(bus.pixel_addr), 0);
        set_pos(639, 479); cyc(); check_vec("map_639_479", 32'(bus.pixel_addr), 76799);
        set_pos(700, 100); cyc(); check_vec("map_hblank", 32'(bus.pixel_addr), 0);
        set_pos(101, 7);   cyc(); check_vec("map_101_7", 32'(bus.pixel_addr), 1010);
        set_pos(10, 500);  cyc(); check_vec("map_vblank", 32'(bus.pixel_addr), 0);

        // deferred step
        set_pos(0, 100);
        bus.dir = 1'b0;
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        check_vec("defer_state", 32'(bus.state), 32'(PEND));
        check_vec("defer_hold", 32'(bus.offset), 0);
        set_pos(0, 479); cyc(); check_vec("defer_479", 32'(bus.offset), 0);
        set_pos(0, 480); cyc(); check_vec("defer_480", 32'(bus.offset), 1);
        check_vec("defer_run", 32'(bus.state), 32'(RUN));
        set_pos(0, 0);   cyc(); check_vec("defer_addr", 32'(bus.pixel_addr), 320);

        // wrap-around
        for (int i = 0; i < 238; i++) do_step(1'b0);
        check_vec("wrap_239", 32'(bus.offset), 239);
        set_pos(0, 0); cyc(); check_vec("wrap_addr_0_0", 32'(bus.pixel_addr), 76480);
        set_pos(0, 2); cyc(); check_vec("wrap_addr_0_2", 32'(bus.pixel_addr), 0);
        set_pos(4, 4); cyc(); check_vec("wrap_addr_4_4", 32'(bus.pixel_addr), 322);
        do_step(1'b0); check_vec("wrap_up", 32'(bus.offset), 0);
        do_step(1'b1); check_vec("wrap_down", 32'(bus.offset), 239);
        do_step(1'b0);
        do_step(1'b0); check_vec("ofs_one", 32'(bus.offset), 1);
        set_pos(0, 478); cyc(); check_vec("wrap_row240", 32'(bus.pixel_addr), 0);

        // cancel
        set_pos(0, 100);
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        bus.en = 1'b0;
        cyc();
        check_vec("cancel_state", 32'(bus.state), 32'(RUN));
        bus.en = 1'b1;
        set_pos(0, 480); cyc(); check_vec("cancel_ofs", 32'(bus.offset), 1);

        // drop extra ticks
        set_pos(0, 100);
        bus.tick = 1'b1; cyc();
        bus.tick = 1'b0; cyc();
        bus.tick = 1'b1; cyc();
        bus.tick = 1'b1; cyc();
        bus.tick = 1'b0;
        check_vec("drop_hold", 32'(bus.offset), 1);
        set_pos(0, 480); cyc(); check_vec("drop_ofs", 32'(bus.offset), 2);
        set_pos(0, 481); cyc(); check_vec("drop_stay", 32'(bus.offset), 2);
        check_vec("drop_state", 32'(bus.state), 32'(RUN));

        // mid-frame reset with a step pending
        repeat (3) do_step(1'b0);
        check_vec("mid_ofs5", 32'(bus.offset), 5);
        bus.valid_in = 1'b1;
        bus.hsync_in = 1'b0;
        bus.vsync_in = 1'b0;
        set_pos(0, 200);
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        check_vec("mid_pend", 32'(bus.state), 32'(PEND));
        cyc();
        check_vec("mid_valid_pre", 32'(bus.valid_out), 1);
        rst = 1'b1;
        cyc();
        check_vec("mid_rst_ofs", 32'(bus.offset), 0);
        check_vec("mid_rst_state", 32'(bus.state), 32'(RUN));
        check_vec("mid_rst_valid", 32'(bus.valid_out), 0);
        check_vec("mid_rst_hsync", 32'(bus.hsync_out), 1);
        check_vec("mid_rst_vsync", 32'(bus.vsync_out), 1);
        rst = 1'b0;
        set_pos(0, 480); cyc(); check_vec("mid_no_step", 32'(bus.offset), 0);

        // sync alignment
        pat_valid = 16'hB38D;
        pat_hsync = 16'h6E1C;
        pat_vsync = 16'hC3A5;
        exp_q1.delete();
        exp_q2.delete();
        for (int t = 0; t < 24; t++) begin
            logic [2:0] vec;
            logic [2:0] exp_v;
            vec = {pat_valid[t % 16], pat_hsync[t % 16], pat_vsync[t % 16]};
            bus.valid_in = vec[2];
            bus.hsync_in = vec[1];
            bus.vsync_in = vec[0];
            exp_q1.push_back(vec);
            exp_q2.push_back(vec);
            cyc();
            if (exp_q1.size() == 2) begin
                exp_v = exp_q1.pop_front();
                check_vec("sync1", 32'({bus.valid_out, bus.hsync_out, bus.vsync_out}), 32'(exp_v));
            end
            if (exp_q2.size() == 3) begin
                exp_v = exp_q2.pop_front();
                check_vec("sync2", 32'({bus2.valid_out, bus2.hsync_out, bus2.vsync_out}), 32'(exp_v));
            end
        end

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
